// File: rtl/ysyx_24080006_csr_hpm.sv
// ysyx_24080006 machine-mode CSR file with HPM counters,
// vectored mtvec, generic trap entry and timer/external irqs.
module ysyx_24080006_csr_hpm #(
  parameter int NUM_HPM = 8,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               csr_en,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               trap_valid,
  input  logic [31:0]        trap_cause,
  input  logic [31:0]        trap_pc,
  input  logic               mret,
  output logic [31:0]        trap_vector,
  output logic [31:0]        mepc_o,
  input  logic               instret,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               irq_timer,
  input  logic               irq_external,
  output logic               irq_pending,
  output logic [31:0]        irq_cause
);

  localparam int LAST = 2 + NUM_HPM;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             mie_q, mpie_q;
  logic             mtie_q, meie_q;
  logic             mtip_q, meip_q;
  logic [31:0]      tvec_q, scratch_q;
  logic [31:0]      mepc_q, mcause_q;
  logic [31:0]      inh_q;
  logic [4:0]       sel_q [32];
  logic [CNT_W-1:0] cnt_q [32];

  logic [4:0]  idx;
  logic        is_lo, is_hi, is_evt;
  logic        hit, ro;
  logic [31:0] wval;
  logic        csr_we;
  logic [63:0] cnt_rd;
  logic [31:0] inh_mask;
  logic [31:0] src, inc;
  logic        unused_pc;

  function automatic logic impl(int i);
    return (i == 0) || (i == 2) ||
           (i >= 3 && i <= LAST);
  endfunction

  assign unused_pc = trap_pc[0];
  assign idx    = csr_addr[4:0];
  assign is_lo  = (csr_addr[11:5] == 7'h58) &&
                  (idx != 5'd1);
  assign is_hi  = (csr_addr[11:5] == 7'h5C) &&
                  (idx != 5'd1);
  assign is_evt = (csr_addr[11:5] == 7'h19) &&
                  (idx >= 5'd3);
  assign cnt_rd = 64'(cnt_q[idx]);

  // writable mcountinhibit bits: mcycle, minstret, implemented HPMs
  always_comb begin
    inh_mask = '0;
    for (int i = 0; i < 32; i++)
      inh_mask[i] = impl(i);
  end

  // read mux and address legality
  always_comb begin
    csr_rdata = '0;
    hit       = 1'b1;
    ro        = 1'b0;
    unique case (1'b1)
      csr_addr == 12'h300:
        csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q,
                     3'b0, mie_q, 3'b0};
      csr_addr == 12'h304:
        csr_rdata = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
      csr_addr == 12'h305: csr_rdata = tvec_q;
      csr_addr == 12'h320: csr_rdata = inh_q;
      is_evt: csr_rdata = {27'b0, sel_q[idx]};
      csr_addr == 12'h340: csr_rdata = scratch_q;
      csr_addr == 12'h341: csr_rdata = mepc_q;
      csr_addr == 12'h342: csr_rdata = mcause_q;
      csr_addr == 12'h344: begin
        csr_rdata = {20'b0, meip_q, 3'b0, mtip_q, 7'b0};
        ro        = 1'b1;
      end
      is_lo: csr_rdata = cnt_rd[31:0];
      is_hi: csr_rdata = cnt_rd[63:32];
      csr_addr == 12'hF11: begin
        csr_rdata = 32'h7973_7978;
        ro        = 1'b1;
      end
      csr_addr == 12'hF12: begin
        csr_rdata = 32'd24080006;
        ro        = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

  assign csr_illegal = csr_en &&
    (!hit || (ro && csr_op != 2'b00));

  // write data from op
  always_comb begin
    unique case (csr_op)
      2'b10:   wval = csr_rdata | csr_wdata;
      2'b11:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  assign csr_we = csr_en && (csr_op != 2'b00) &&
                  !csr_illegal && !trap_valid && !mret;

  // per-counter increment source
  always_comb begin
    src    = '0;
    src[0] = 1'b1;
    src[2] = instret;
    for (int i = 3; i < 32; i++)
      for (int k = 0; k < NUM_EVT; k++)
        if (sel_q[i] == 5'(k + 1))
          src[i] = src[i] | evt[k];
  end

  assign inc = src & ~inh_q;

  // status, trap state, plain CSRs and mip sampling
  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mtie_q    <= 1'b0;
      meie_q    <= 1'b0;
      mtip_q    <= 1'b0;
      meip_q    <= 1'b0;
      tvec_q    <= '0;
      scratch_q <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      inh_q     <= '0;
    end else begin
      mtip_q <= irq_timer;
      meip_q <= irq_external;
      if (trap_valid) begin
        mcause_q <= trap_cause;
        mepc_q   <= {trap_pc[31:1], 1'b0};
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: begin
            mie_q  <= wval[3];
            mpie_q <= wval[7];
          end
          12'h304: begin
            mtie_q <= wval[7];
            meie_q <= wval[11];
          end
          12'h305: tvec_q    <= wval & 32'hFFFF_FFFD;
          12'h320: inh_q     <= wval & inh_mask;
          12'h340: scratch_q <= wval;
          12'h341: mepc_q    <= {wval[31:1], 1'b0};
          12'h342: mcause_q  <= wval;
          default: ;
        endcase
      end
    end
  end

  // counters and event selectors; unimplemented slots stay zero
  always_ff @(posedge clock) begin
    for (int i = 0; i < 32; i++) begin
      if (reset || !impl(i)) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end else begin
        if (csr_we && is_evt && idx == 5'(i))
          sel_q[i] <= wval[4:0];
        if (csr_we && is_lo && idx == 5'(i))
          cnt_q[i] <= {cnt_q[i][CNT_W-1:32], wval};
        else if (csr_we && is_hi && idx == 5'(i))
          cnt_q[i] <= {wval[CNT_W-33:0], cnt_q[i][31:0]};
        else if (inc[i])
          cnt_q[i] <= cnt_q[i] + ONE;
      end
    end
  end

  assign trap_vector = {tvec_q[31:2], 2'b00} +
    ((tvec_q[0] && trap_cause[31]) ?
     {25'b0, trap_cause[4:0], 2'b00} : 32'b0);

  assign mepc_o = mepc_q;

  assign irq_pending = mie_q &&
    ((mtie_q && mtip_q) || (meie_q && meip_q));

  assign irq_cause = (meie_q && meip_q) ? 32'h8000_000B :
                     (mtie_q && mtip_q) ? 32'h8000_0007 :
                     32'h0;

endmodule

// File: doc/ysyx_24080006_csr_hpm.md
# ysyx_24080006_csr_hpm

Parametrised machine-mode CSR file for the ysyx_24080006 core, successor to the fixed-configuration CSR unit. It adds:
- a configurable number of writable hardware performance counters with programmable event selection and configurable width;
- a generic trap entry driven by an arbitrary cause;
- vectored mtvec;
- timer/external interrupt enable/pending logic.

It sits beside the execute stage, serving CSR instructions, trap entry and mret.

## Interface
- NUM_HPM, 8, implemented mhpmcounter3.. count (0..29)
- CNT_W, 64, counter width in bits (33..64)
- NUM_EVT, 16, event input count (1..31)
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  00 read, 01 write, 10 set, 11 clear
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1/uimm operand
- csr_rdata  out  32  current CSR value (combinational)
- csr_illegal  out  1  csr_en and illegal access (combinational)
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  mcause value (bit31 = interrupt)
- trap_pc  in  32  faulting/interrupted pc
- mret  in  1  return from trap
- trap_vector  out  32  trap target pc
- mepc_o  out  32  mepc for mret
- instret  in  1  instruction retired
- evt  in  NUM_EVT  one-cycle event pulses
- irq_timer, irq_external  in  1 each  level interrupt requests
- irq_pending  out  1  enabled interrupt pending
- irq_cause  out  32  cause of highest-priority pending interrupt

## Operation
**CSR map** (any other address is illegal):
- mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] fixed 11; all other bits read 0.
- mie 0x304: MTIE[7], MEIE[11] writable.
- mtvec 0x305: base[31:2] and mode[0] writable (0 direct, 1 vectored); bit1 reads 0.
- mcountinhibit 0x320: bit0, bit2 and bits 3..2+NUM_HPM writable; others 0.
- mhpmevent3..31 0x323..0x33F: 5-bit selector, upper bits read 0.
- mscratch 0x340: full 32 bits.
- mepc 0x341: bit0 reads 0.
- mcause 0x342: full 32 bits.
- mip 0x344: read-only; MTIP[7], MEIP[11].
- mcycle 0xB00 / minstret 0xB02 / mhpmcounter3..31 0xB03..0xB1F: low 32 bits.
- mcycleh 0xB80 / minstreth 0xB82 / mhpmcounterNh 0xB83..0xB9F: high bits.
- mvendorid 0xF11 = 0x79737978; marchid 0xF12 = 24080006 (read-only).

**Counters and events**
- Unimplemented counters (index > 2+NUM_HPM) and their mhpmevent/inhibit bits read 0. Writes to them are ignored and not illegal.
- High half returns counter[CNT_W-1:32], zero-extended.
- Index 1 (time) is illegal.
- mhpmevent value k in 1..NUM_EVT selects evt[k-1]. A value of 0 or a value greater than NUM_EVT counts nothing.

**Write data and illegality**
- Write data: write = wdata; set = rdata | wdata; clear = rdata & ~wdata. A read op never writes.
- csr_illegal is raised for an unknown address, or for a write/set/clear op to mip, mvendorid or marchid. An illegal access changes no state.

**Increment and write priority**
- Counter i increments by 1 when its source is active and mcountinhibit[i]=0.
  - mcycle source: always active.
  - minstret source: instret.
  - HPM source: the selected evt.
- Counters wrap modulo 2^CNT_W.
- A CSR write to either half of a counter overrides that cycle's increment for the whole counter. The other half keeps its old value, not incremented.

**Trap and return** (priority trap_valid > mret > CSR write; a lower-priority action in the same cycle is dropped entirely):
- Trap: mcause←trap_cause, mepc←{trap_pc[31:1],0}, MPIE←MIE, MIE←0.
- mret: MIE←MPIE, MPIE←1.

**Trap vector and interrupts**
- trap_vector = {base,00} when mode=0 or trap_cause[31]=0; otherwise {base,00} + 4·trap_cause[4:0].
- mip register samples irq_timer/irq_external every cycle.
- irq_pending = MIE & |(mie & mip).
- irq_cause = 0x8000000B when external is enabled and pending, else 0x80000007 when timer is enabled and pending, else 0.

## Timing
- **Reset:** mstatus=0x1800; all other CSRs, counters and mip = 0. After reset, irq_pending=0, irq_cause=0 and trap_vector=trap_cause-independent 0 (mode 0).
- **Read path:** csr_rdata, csr_illegal and trap_vector are combinational, zero latency. A read returns pre-update state; a write is visible on the next cycle.
- **Counter increment:** visible one cycle after the event pulse.
- **Interrupt path:** 2-stage: an irq input takes 1 cycle to reach mip, then irq_pending asserts combinationally from it.
- **Reset mid-operation:** overrides a simultaneous trap, mret or CSR write.
- **No handshake:** all inputs are single-cycle qualified.

## Test plan
- After reset: read 0x300 → 0x00001800. Read 0xB00 on cycles 1 and 5 → difference 4.
- Write mhpmevent3=2, pulse evt[1] ×3 → mhpmcounter3=3. Set mcountinhibit bit3, pulse evt[1] → value stays 3.
- Write mcycle=0xFFFFFFFF and mcycleh=0 (CNT_W=64), wait 1 cycle → mcycle=0, mcycleh=1. With CNT_W=40, mcycleh=0xFF and mcycle=0xFFFFFFFF → wraps to 0/0.
- mtvec=0x80000001, trap_cause=0x80000007 → trap_vector=0x8000001C. trap_cause=0x0000000B → 0x80000000.
- MIE=1, trap_valid with pc=0x80000103 plus a simultaneous CSR write to mscratch → mepc=0x80000102, MIE=0, MPIE=1, mscratch unchanged. Then mret → MIE=1.
- mie=0x880, MIE=1, raise irq_timer then irq_external → irq_pending 1 cycle after each, irq_cause 0x80000007 then 0x8000000B. Write to 0x344 or 0x7C0 → csr_illegal=1, no state change.
